mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rv32i_types.sv | 10 +
 rtl/arb_priority.sv | 34 +++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the rv32i memory subsystem.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_I   = 2'd1,
    SERVE_LSQ = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_priority.sv
// Grant selection between the fetch and LSQ clients.
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise LSQ has fixed priority.
module arb_priority (
  input  logic i_req,
  input  logic lsq_req,
  input  logic last_grant,   // 1: LSQ was served last, 0: fetch was served last
  output logic grant_i,
  output logic grant_lsq
);

`ifdef MEM_ARB_RR_EN
  // On a tie, the client that was not served last wins.
  always_comb begin
    grant_i   = 1'b0;
    grant_lsq = 1'b0;
    if (i_req && lsq_req) begin
      grant_i   = last_grant;
      grant_lsq = ~last_grant;
    end else begin
      grant_i   = i_req;
      grant_lsq = lsq_req;
    end
  end
`else
  logic unused_last;
  assign unused_last = last_grant;

  always_comb begin
    grant_lsq = lsq_req;
    grant_i   = i_req & ~lsq_req;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (fetch, LSQ) arbiter onto a single downstream memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking instead of LSQ fixed priority.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int width = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [width/8-1:0] i_mem_byte_enable,
  input  logic [width-1:0]   i_mem_address,
  input  logic [width-1:0]   i_mem_wdata,
  output logic               i_mem_resp,
  output logic [width-1:0]   i_mem_rdata,
  input  logic               lsq_mem_read,
  input  logic               lsq_mem_write,
  input  logic [width/8-1:0] lsq_mem_byte_enable,
  input  logic [width-1:0]   lsq_mem_address,
  input  logic [width-1:0]   lsq_mem_wdata,
  output logic               lsq_mem_resp,
  output logic [width-1:0]   lsq_mem_rdata,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [width/8-1:0] pmem_byte_enable,
  output logic [width-1:0]   pmem_address,
  output logic [width-1:0]   pmem_wdata,
  input  logic               pmem_resp,
  input  logic [width-1:0]   pmem_rdata
);

  localparam int BW = width / 8;

  arb_state_t        state, state_next;
  logic              r_read, r_write;
  logic [BW-1:0]     r_be;
  logic [width-1:0]  r_addr, r_wdata;
  logic              i_req, lsq_req, grant_i, grant_lsq, take, last_grant;

  assign i_req   = i_mem_read | i_mem_write;
  assign lsq_req = lsq_mem_read | lsq_mem_write;

  arb_priority u_prio (
    .i_req      (i_req),
    .lsq_req    (lsq_req),
    .last_grant (last_grant),
    .grant_i    (grant_i),
    .grant_lsq  (grant_lsq)
  );

  // A completion seen in IDLE never coincides with a new grant.
  assign take = (state == IDLE) && !pmem_resp && (grant_i || grant_lsq);

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      last_grant <= 1'b0;
    else if (take) last_grant <= grant_lsq;
  end
`else
  assign last_grant = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:              if (take) state_next = grant_lsq ? SERVE_LSQ : SERVE_I;
      SERVE_I, SERVE_LSQ: if (pmem_resp) state_next = IDLE;
      default:           state_next = IDLE;
    endcase
  end

  // Read+write together is latched as a pure write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (take) begin
      if (grant_lsq) begin
        r_read  <= lsq_mem_read & ~lsq_mem_write;
        r_write <= lsq_mem_write;
        r_be    <= lsq_mem_byte_enable;
        r_addr  <= lsq_mem_address;
        r_wdata <= lsq_mem_wdata;
      end else begin
        r_read  <= i_mem_read & ~i_mem_write;
        r_write <= i_mem_write;
        r_be    <= i_mem_byte_enable;
        r_addr  <= i_mem_address;
        r_wdata <= i_mem_wdata;
      end
    end else if ((state != IDLE) && pmem_resp) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end
  end

  assign pmem_read        = r_read;
  assign pmem_write       = r_write;
  assign pmem_byte_enable = r_be;
  assign pmem_address     = r_addr;
  assign pmem_wdata       = r_wdata;

  // A client that has dropped its request gets no completion pulse.
  always_comb begin
    i_mem_resp    = 1'b0;
    i_mem_rdata   = '0;
    lsq_mem_resp  = 1'b0;
    lsq_mem_rdata = '0;
    if ((state == SERVE_I) && pmem_resp && i_req) begin
      i_mem_resp  = 1'b1;
      i_mem_rdata = pmem_rdata;
    end
    if ((state == SERVE_LSQ) && pmem_resp && lsq_req) begin
      lsq_mem_resp  = 1'b1;
      lsq_mem_rdata = pmem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
  import rv32i_types::*;

  localparam int W  = 32;
  localparam int BW = W / 8;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_mem_read = 1'b0, i_mem_write = 1'b0;
  logic [BW-1:0] i_mem_byte_enable = '0;
  logic [W-1:0]  i_mem_address = '0, i_mem_wdata = '0;
  logic          i_mem_resp;
  logic [W-1:0]  i_mem_rdata;
  logic          lsq_mem_read = 1'b0, lsq_mem_write = 1'b0;
  logic [BW-1:0] lsq_mem_byte_enable = '0;
  logic [W-1:0]  lsq_mem_address = '0, lsq_mem_wdata = '0;
  logic          lsq_mem_resp;
  logic [W-1:0]  lsq_mem_rdata;
  logic          pmem_read, pmem_write;
  logic [BW-1:0] pmem_byte_enable;
  logic [W-1:0]  pmem_address, pmem_wdata;
  logic          pmem_resp = 1'b0;
  logic [W-1:0]  pmem_rdata = '0;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_byte_enable(i_mem_byte_enable), .i_mem_address(i_mem_address),
    .i_mem_wdata(i_mem_wdata), .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
    .lsq_mem_read(lsq_mem_read), .lsq_mem_write(lsq_mem_write),
    .lsq_mem_byte_enable(lsq_mem_byte_enable), .lsq_mem_address(lsq_mem_address),
    .lsq_mem_wdata(lsq_mem_wdata), .lsq_mem_resp(lsq_mem_resp), .lsq_mem_rdata(lsq_mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_byte_enable(pmem_byte_enable),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner of the downstream port (0 none, 1 fetch, 2 LSQ) and the request it was given.
  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [BW-1:0] be;
    logic [W-1:0]  addr;
    logic [W-1:0]  wd;
  } req_t;

  int   m_owner    = 0;
  req_t m_req      = '0;
  logic m_last_lsq = 1'b0;

  function automatic int pick(input bit fi, input bit fl, input logic last_lsq);
    if (fi && fl) begin
      if (RR) return last_lsq ? 1 : 2;
      return 2;
    end
    if (fl) return 2;
    if (fi) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    int w;
    if (!rst) begin
      m_owner    = 0;
      m_req      = '0;
      m_last_lsq = 1'b0;
    end else if (m_owner == 0) begin
      w = pick(i_mem_read | i_mem_write, lsq_mem_read | lsq_mem_write, m_last_lsq);
      if (!pmem_resp && w != 0) begin
        m_owner = w;
        if (w == 1)
          m_req = '{rd: i_mem_read && !i_mem_write, wr: i_mem_write, be: i_mem_byte_enable,
                    addr: i_mem_address, wd: i_mem_wdata};
        else
          m_req = '{rd: lsq_mem_read && !lsq_mem_write, wr: lsq_mem_write, be: lsq_mem_byte_enable,
                    addr: lsq_mem_address, wd: lsq_mem_wdata};
        m_last_lsq = (w == 2);
      end
    end else if (pmem_resp) begin
      m_owner = 0;
      m_req   = '0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic e_i, e_l;
    e_i = (m_owner == 1) && pmem_resp && (i_mem_read || i_mem_write);
    e_l = (m_owner == 2) && pmem_resp && (lsq_mem_read || lsq_mem_write);
    chk("m pmem_read", pmem_read, m_req.rd);
    chk("m pmem_write", pmem_write, m_req.wr);
    chk("m pmem_be", pmem_byte_enable, m_req.be);
    chk("m pmem_addr", pmem_address, m_req.addr);
    chk("m pmem_wdata", pmem_wdata, m_req.wd);
    chk("m i_resp", i_mem_resp, e_i);
    chk("m i_rdata", i_mem_rdata, e_i ? pmem_rdata : '0);
    chk("m lsq_resp", lsq_mem_resp, e_l);
    chk("m lsq_rdata", lsq_mem_rdata, e_l ? pmem_rdata : '0);
  end

  // ---------------- downstream memory responder ----------------
  int           lat = 3;
  logic [W-1:0] rdv = '0;
  int           cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        = 0;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
    end else begin
      #1;
      if (pmem_resp) begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        cnt        = 0;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt >= lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = pmem_read ? rdv : '0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input bit lsq, input int budget, output bit seen,
                           output logic [W-1:0] rd, output int cycles);
    seen   = 1'b0;
    rd     = '0;
    cycles = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      cycles++;
      if (lsq ? lsq_mem_resp : i_mem_resp) begin
        seen = 1'b1;
        rd   = lsq ? lsq_mem_rdata : i_mem_rdata;
      end
    end
  endtask

  // ---------------- directed scenarios ----------------
  logic [W-1:0] exp_q[$];

  initial begin
    bit           seen;
    logic [W-1:0] rd;
    int           cyc;
    int           extra;

    repeat (2) @(posedge clk);
    #1;
    chk("rst pmem_read", pmem_read, 0);
    chk("rst i_resp", i_mem_resp, 0);
    chk("rst lsq_rdata", lsq_mem_rdata, 0);
    rst = 1'b1;
    tick();
    chk("post rst pmem_write", pmem_write, 0);
    chk("post rst pmem_addr", pmem_address, 0);

    // Fetch read alone, memory answers on the third downstream cycle.
    lat = 3; rdv = 32'h0000_0013;
    i_mem_read = 1'b1; i_mem_address = 32'h0000_0040; i_mem_byte_enable = 4'hF;
    @(negedge clk);
    chk("t1 pmem_read same cycle", pmem_read, 0);
    tick();
    chk("t1 pmem_read next cycle", pmem_read, 1);
    chk("t1 pmem_addr", pmem_address, 32'h40);
    wait_resp(1'b0, 10, seen, rd, cyc);
    chk("t1 resp seen", seen, 1);
    chk("t1 resp rdata", rd, 32'h13);
    chk("t1 resp latency", cyc, 3);
    tick();
    i_mem_read = 1'b0;
    chk("t1 pmem_read dropped", pmem_read, 0);
    chk("t1 resp one cycle", i_mem_resp, 0);
    tick();

    // LSQ write, held until completion.
    lat = 2;
    lsq_mem_write = 1'b1; lsq_mem_address = 32'h100; lsq_mem_wdata = 32'hDEADBEEF;
    lsq_mem_byte_enable = 4'hF;
    tick();
    chk("t2 pmem_write", pmem_write, 1);
    chk("t2 pmem_addr", pmem_address, 32'h100);
    chk("t2 pmem_wdata", pmem_wdata, 32'hDEADBEEF);
    wait_resp(1'b1, 10, seen, rd, cyc);
    chk("t2 resp seen", seen, 1);
    tick();
    lsq_mem_write = 1'b0;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (lsq_mem_resp) extra++;
    end
    chk("t2 extra resp", extra, 0);
    tick();

`ifndef MEM_ARB_RR_EN
    // Simultaneous requests: LSQ first, one idle cycle, then fetch.
    lat = 2; rdv = 32'h0000_0055;
    i_mem_read = 1'b1;   i_mem_address = 32'h200;
    lsq_mem_read = 1'b1; lsq_mem_address = 32'h300;
    tick();
    chk("t3 first addr", pmem_address, 32'h300);
    wait_resp(1'b1, 10, seen, rd, cyc);
    chk("t3 lsq resp", seen, 1);
    chk("t3 lsq rdata", rd, 32'h55);
    tick();
    lsq_mem_read = 1'b0;
    chk("t3 idle gap", pmem_read, 0);
    tick();
    chk("t3 second addr", pmem_address, 32'h200);
    chk("t3 second read", pmem_read, 1);
    wait_resp(1'b0, 10, seen, rd, cyc);
    chk("t3 fetch resp", seen, 1);
    tick();
    i_mem_read = 1'b0;
    tick();
`else
    // Continuous requests from both: grants alternate starting with fetch.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    lat = 1;
    i_mem_read = 1'b1; i_mem_address = 32'h400;
    tick();
    lsq_mem_read = 1'b1; lsq_mem_address = 32'h500;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(2);
    for (int k = 0; k < 80 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      if (i_mem_resp)   chk("t4 grant order", 1, exp_q.pop_front());
      if (lsq_mem_resp) chk("t4 grant order", 2, exp_q.pop_front());
    end
    chk("t4 grants left", exp_q.size(), 0);
    tick();
    i_mem_read = 1'b0; lsq_mem_read = 1'b0;
    repeat (3) tick();
`endif

    // Fetch abandons its request after grant; completion is swallowed.
    lat = 4;
    i_mem_read = 1'b1; i_mem_address = 32'h600;
    tick();
    chk("t5 granted", pmem_read, 1);
    tick();
    i_mem_read = 1'b0;
    wait_resp(1'b0, 8, seen, rd, cyc);
    chk("t5 no resp", seen, 0);
    chk("t5 back idle", dut.state, IDLE);
    chk("t5 pmem_read low", pmem_read, 0);
    tick();

    // Reset during an LSQ transaction.
    lat = 6;
    lsq_mem_read = 1'b1; lsq_mem_address = 32'h700;
    tick();
    chk("t6 granted", pmem_read, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("t6 pmem_read async", pmem_read, 0);
    chk("t6 pmem_write async", pmem_write, 0);
    chk("t6 state idle", dut.state, IDLE);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (lsq_mem_resp) extra++;
    end
    chk("t6 no lsq resp", extra, 0);
    lsq_mem_read = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("t6 idle after", pmem_read, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
